aes_byte_host: RTL
==================

# aes_byte_host

Host-side driver and collector for the byte-serial AES encryption core. Accepts a 128-bit key and plaintext block on a valid/ready handshake and streams them into the core one byte per cycle, timed to the core's load behaviour. It then waits for the core's `ready`, gathers the 16 ciphertext bytes, and presents the 128-bit result downstream. It sits between a parallel bus client and the `AES_encryption` core, and also provides that core's synchronous active-high reset.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in WAIT without `ready_i` before the block aborts.
- `clk` in 1: single clock, shared with the core.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `in_key` in 128: AES-128 key. Byte k is `in_key[127-8k -: 8]`.
- `in_block` in 128: plaintext block, same byte order as `in_key`.
- `out_valid` out 1: ciphertext valid. Held until accepted.
- `out_ready` in 1: downstream accepts the result.
- `out_block` out 128: ciphertext. Byte k is `out_block[127-8k -: 8]`.
- `err` out 1: one-cycle pulse on timeout abort.
- `core_rst_o` out 1: core reset, synchronous active-high.
- `enable_o` out 1: drives the core's `enable`.
- `key_byte_o` out 8: drives the core's `key_byte`.
- `state_byte_o` out 8: drives the core's `state_byte`.
- `ready_i` in 1: from the core's `ready`.
- `state_out_byte_i` in 8: from the core's `state_out_byte`.
- The core's `load` output is not used.

## Operation
- States: IDLE, LOAD, WAIT, COLLECT, DONE, ABORT. All outputs are registered. `key_byte_o` and `state_byte_o` may be a mux from registered storage indexed by a registered counter.
- Reset values (asserted while `rst`=0):
  - `in_ready`=0, `out_valid`=0, `out_block`=0, `err`=0, `enable_o`=0.
  - `key_byte_o`=0, `state_byte_o`=0, `core_rst_o`=1, state=IDLE.
- After reset release:
  - First edge: `core_rst_o`←0.
  - Second edge: `in_ready`←1.
- IDLE: `in_ready`=1. On edge A with `in_valid`&&`in_ready`:
  - latch key and block; `in_ready`←0; `enable_o`←1; byte counter←0; go to LOAD.
- LOAD:
  - Byte k (key and block) is driven on `key_byte_o`/`state_byte_o` through the edge A+2+k, for k=0..15. The core samples byte k at that edge.
  - Byte 0 is valid from edge A onward.
  - At edge A+17, go to WAIT with the timeout counter at 0.
- WAIT:
  - `ready_i` sampled 1 → go to COLLECT with the byte counter at 0. That edge is F+1, where F is the edge at which the core raised `ready`.
  - Else increment the timeout counter. When it reaches `TIMEOUT_CYCLES`, go to ABORT.
- COLLECT:
  - At edges F+2..F+17, capture `state_out_byte_i` into byte k (k=0..15).
  - At edge F+17: `out_block`←assembled value, `out_valid`←1, `enable_o`←0, go to DONE.
- DONE: hold `out_valid` and `out_block` stable until `out_valid`&&`out_ready` at an edge. Then `out_valid`←0, `in_ready`←1, go to IDLE.
- ABORT (one cycle): `enable_o`←0, `core_rst_o`←1, `err`←1. At the next edge: `core_rst_o`←0, `err`←0, `in_ready`←1, go to IDLE. No `out_valid` is produced.
- `ready_i` is ignored in IDLE, LOAD, DONE and ABORT.
- `in_valid` is ignored outside IDLE. Request fields are sampled only at edge A.

## Timing
- Accept to last byte sampled by the core: 17 cycles.
- Core `ready` rise (F) to `out_valid`: 17 cycles.
- Minimum gap between DONE→IDLE and the next accept: 1 cycle. `enable_o` is 0 at that point, so the core is back in its state 0.
- `out_ready` held at 1: `out_valid` is high for exactly one cycle.
- Asynchronous reset mid-operation: all outputs go to reset values immediately and `core_rst_o`=1. Any partial result is discarded and no `err` pulse is generated.
- The timeout counter is wide enough for `TIMEOUT_CYCLES`, holds at its terminal value, and clears on leaving WAIT.

## Test plan
- FIPS-197 vector with the real core: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff → `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a, `err` never 1.
- Byte alignment with a behavioural core model: key 0x00..0x0f, block 0xf0..0xff → model sees bytes 00/f0 at edge A+2 and 0f/ff at edge A+17; `enable_o` high from A+1 through F+17.
- Collection with a model that raises `ready` at F and then drives bytes 0x10..0x1f at F+1..F+16 → `out_block`=101112131415161718191a1b1c1d1e1f and `out_valid` at F+17.
- Back-pressure with the real core: `out_ready`=0 for 5 cycles after `out_valid` → `out_block` stable, `in_ready`=0 throughout; then `out_ready`=1 → `in_ready`=1 one cycle later; back-to-back second vector correct.
- Timeout: model never raises `ready`, `TIMEOUT_CYCLES`=20 → `err` and `core_rst_o` pulse for one cycle, 20 cycles after WAIT entry; `enable_o`=0; `in_ready` returns 1.
- Reset mid-LOAD and mid-COLLECT: drop `rst` asynchronously → outputs at reset values without waiting for a clock edge; after release, the FIPS-197 vector passes.

Source files
------------

// File: rtl/aes_byte_host.sv
// aes_byte_host: host-side driver/collector for the byte-serial AES-128 core.
// Takes a 128-bit key and plaintext on a valid/ready handshake and streams
// them into the core one byte per cycle. It then waits for the core's ready,
// gathers the 16 ciphertext bytes and holds the 128-bit result until
// downstream accepts it. It also owns the core's synchronous active-high reset.
module aes_byte_host #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         err,
  output logic         core_rst_o,
  output logic         enable_o,
  output logic [7:0]   key_byte_o,
  output logic [7:0]   state_byte_o,
  input  logic         ready_i,
  input  logic [7:0]   state_out_byte_i
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT count before the abort; the edge that would reach TIMEOUT_CYCLES aborts.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_COLLECT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t        r_state;
  logic [127:0]  r_key;
  logic [127:0]  r_block;
  logic [127:0]  r_collect;
  logic [4:0]    r_cnt;
  logic [TW-1:0] r_tcnt;

  // Byte k of a 128-bit word, byte 0 being the most significant.
  function automatic logic [7:0] byte_of(input logic [127:0] v, input logic [3:0] idx);
    return v[8*(15 - int'(idx)) +: 8];
  endfunction

  // Control FSM with all outputs registered; byte lanes are driven directly from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_block    <= '0;
      err          <= 1'b0;
      core_rst_o   <= 1'b1;
      enable_o     <= 1'b0;
      key_byte_o   <= '0;
      state_byte_o <= '0;
      // NOTE: the data registers are cleared too; they are few, and a known
      // value after reset keeps partial results from a previous run invisible.
      r_key        <= '0;
      r_block      <= '0;
      r_collect    <= '0;
      r_cnt        <= '0;
      r_tcnt       <= '0;
    end else begin
      // NOTE: a non-blocking default here is overridden by any later
      // non-blocking assignment in the same pass, which makes err a pulse.
      err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (core_rst_o) begin
            core_rst_o <= 1'b0;
          end else if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            r_key        <= in_key;
            r_block      <= in_block;
            in_ready     <= 1'b0;
            enable_o     <= 1'b1;
            r_cnt        <= '0;
            key_byte_o   <= in_key[127:120];
            state_byte_o <= in_block[127:120];
            r_state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Byte k is presented after edge A+1+k and sampled by the core at A+2+k.
          if (r_cnt == 5'd16) begin
            key_byte_o   <= '0;
            state_byte_o <= '0;
            r_tcnt       <= '0;
            r_state      <= S_WAIT;
          end else begin
            key_byte_o   <= byte_of(r_key, r_cnt[3:0]);
            state_byte_o <= byte_of(r_block, r_cnt[3:0]);
            r_cnt        <= r_cnt + 5'd1;
          end
        end

        S_WAIT: begin
          if (ready_i) begin
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_state <= S_COLLECT;
          end else if (r_tcnt >= TCNT_LAST) begin
            r_tcnt     <= '0;
            enable_o   <= 1'b0;
            core_rst_o <= 1'b1;
            err        <= 1'b1;
            r_state    <= S_ABORT;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end

        S_COLLECT: begin
          r_collect <= {r_collect[119:0], state_out_byte_i};
          r_cnt     <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            out_block <= {r_collect[119:0], state_out_byte_i};
            out_valid <= 1'b1;
            enable_o  <= 1'b0;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        S_ABORT: begin
          core_rst_o <= 1'b0;
          in_ready   <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
